// File: rtl/micro_sequencer.sv
// micro_sequencer: next-microaddress generator for the microprogrammed control
// unit. It provides increment, jump, dispatch, conditional branch, conditional
// wait, and call/return through a small LIFO of return addresses, plus restart.
// upc and every other output come straight from registers.
module micro_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int COND_N      = 4,
  parameter int SEL_W       = 2,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  parameter int FETCH_ADDR  = 1
) (
  input  logic                                 CLK,
  input  logic                                 reset,
  input  logic                                 stall,
  input  logic [2:0]                           ns_op,
  input  logic [ADDR_W-1:0]                    target,
  input  logic [ADDR_W-1:0]                    dispatch_addr,
  input  logic [COND_N-1:0]                    cond_in,
  input  logic [SEL_W-1:0]                     cond_sel,
  input  logic                                 cond_inv,
  output logic [ADDR_W-1:0]                    upc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_level,
  output logic                                 stack_ovf,
  output logic                                 stack_unf
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic [2:0] {
    OP_CONT     = 3'b000,
    OP_JUMP     = 3'b001,
    OP_DISPATCH = 3'b010,
    OP_CBR      = 3'b011,
    OP_CWAIT    = 3'b100,
    OP_CALL     = 3'b101,
    OP_RET      = 3'b110,
    OP_RESTART  = 3'b111
  } ns_op_t;

  ns_op_t op;
  assign op = ns_op_t'(ns_op);

  logic [ADDR_W-1:0]             upc_reg, upc_next;
  logic [LVL_W-1:0]              level_reg, level_next;
  logic                          ovf_reg, ovf_next;
  logic                          unf_reg, unf_next;
  logic                          push;
  logic                          sel_cond;
  logic                          test;
  logic [ADDR_W-1:0]             inc;
  logic [ADDR_W-1:0]             pop_val;
  logic [STACK_DEPTH*ADDR_W-1:0] stack_flat;

  assign inc  = upc_reg + ADDR_W'(1);
  assign test = sel_cond ^ cond_inv;

  // Select the addressed condition; selectors beyond the bank read as 0.
  always_comb begin
    sel_cond = 1'b0;
    for (int i = 0; i < COND_N; i++) begin
      if (cond_sel == SEL_W'(i)) sel_cond = cond_in[i];
    end
  end

  // Read the top-of-stack entry, i.e. entry[level-1].
  always_comb begin
    pop_val = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (level_reg == LVL_W'(i + 1)) pop_val = stack_flat[i*ADDR_W +: ADDR_W];
    end
  end

  // Next-address, stack-level and flag computation; stall freezes everything.
  always_comb begin
    upc_next   = upc_reg;
    level_next = level_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    push       = 1'b0;
    if (!stall) begin
      case (op)
        OP_CONT:     upc_next = inc;
        OP_JUMP:     upc_next = target;
        OP_DISPATCH: upc_next = dispatch_addr;
        OP_CBR:      upc_next = test ? target : inc;
        OP_CWAIT:    upc_next = test ? inc : upc_reg;
        OP_CALL: begin
          // The jump is always taken; only the push is lost when full.
          upc_next = target;
          if (level_reg == LVL_W'(STACK_DEPTH)) begin
            ovf_next = 1'b1;
          end else begin
            push       = 1'b1;
            level_next = level_reg + LVL_W'(1);
          end
        end
        OP_RET: begin
          // A return with nothing on the stack restarts the fetch loop.
          if (level_reg == '0) begin
            upc_next = ADDR_W'(FETCH_ADDR);
            unf_next = 1'b1;
          end else begin
            upc_next   = pop_val;
            level_next = level_reg - LVL_W'(1);
          end
        end
        OP_RESTART: begin
          upc_next   = ADDR_W'(FETCH_ADDR);
          level_next = '0;
        end
        default: upc_next = upc_reg;
      endcase
    end
  end

  // Microaddress, stack level and sticky error flags.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      upc_reg   <= ADDR_W'(RESET_ADDR);
      level_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      upc_reg   <= upc_next;
      level_reg <= level_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // One register per return-stack entry, written when a push targets it.
  generate
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
      logic [ADDR_W-1:0] entry_reg;

      // Capture the return address when this slot is the current level.
      always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (push && level_reg == LVL_W'(gi)) begin
          entry_reg <= inc;
        end
      end

      assign stack_flat[gi*ADDR_W +: ADDR_W] = entry_reg;
    end
  endgenerate

  assign upc         = upc_reg;
  assign stack_level = level_reg;
  assign stack_ovf   = ovf_reg;
  assign stack_unf   = unf_reg;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: each step pushes its expected
// outcome to a scoreboard and pops it after the clock edge to compare.
module tb_micro_sequencer;

  localparam int ADDR_W = 8;
  localparam int COND_N = 3;
  localparam int SEL_W  = 2;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  localparam logic [2:0] CONT = 3'd0, JUMP = 3'd1, DISP = 3'd2, CBR = 3'd3,
                         CWAIT = 3'd4, CALL = 3'd5, RET = 3'd6, RESTART = 3'd7;

  logic              CLK = 1'b0;
  logic              reset;
  logic              stall;
  logic [2:0]        ns_op;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] dispatch_addr;
  logic [COND_N-1:0] cond_in;
  logic [SEL_W-1:0]  cond_sel;
  logic              cond_inv;
  logic [ADDR_W-1:0] upc;
  logic [LVL_W-1:0]  stack_level;
  logic              stack_ovf;
  logic              stack_unf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string             tag;
    logic [ADDR_W-1:0] upc;
    logic [LVL_W-1:0]  lvl;
    logic              ovf;
    logic              unf;
  } exp_t;

  exp_t sb[$];

  micro_sequencer #(
    .ADDR_W(ADDR_W), .COND_N(COND_N), .SEL_W(SEL_W),
    .STACK_DEPTH(DEPTH), .RESET_ADDR(0), .FETCH_ADDR(1)
  ) dut (
    .CLK(CLK), .reset(reset), .stall(stall), .ns_op(ns_op), .target(target),
    .dispatch_addr(dispatch_addr), .cond_in(cond_in), .cond_sel(cond_sel),
    .cond_inv(cond_inv), .upc(upc), .stack_level(stack_level),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one microinstruction (condition/stall inputs as currently set),
  // clock it and compare all outputs against the scoreboard entry.
  task automatic step(input string tag, input logic [2:0] op, input logic [ADDR_W-1:0] tgt,
                      input int e_upc, input int e_lvl, input logic e_ovf, input logic e_unf);
    exp_t e;
    ns_op  = op;
    target = tgt;
    sb.push_back('{tag, ADDR_W'(e_upc), LVL_W'(e_lvl), e_ovf, e_unf});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check({e.tag, ".upc"}, 32'(upc), 32'(e.upc));
    check({e.tag, ".lvl"}, 32'(stack_level), 32'(e.lvl));
    check({e.tag, ".ovf"}, 32'(stack_ovf), 32'(e.ovf));
    check({e.tag, ".unf"}, 32'(stack_unf), 32'(e.unf));
    $display("%-12s op=%0d tgt=%0d -> upc=%0d lvl=%0d ovf=%0b unf=%0b",
             e.tag, op, tgt, upc, stack_level, stack_ovf, stack_unf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; ns_op = CONT; target = '0; dispatch_addr = '0;
    cond_in = '0; cond_sel = '0; cond_inv = 1'b0;
    #12;
    check("reset.upc", 32'(upc), 32'd0);
    check("reset.lvl", 32'(stack_level), 32'd0);
    check("reset.ovf", 32'(stack_ovf), 32'd0);
    check("reset.unf", 32'(stack_unf), 32'd0);
    reset = 1'b0;

    // Sequential increment and wrap.
    step("cont1", CONT, 0, 1, 0, 0, 0);
    step("cont2", CONT, 0, 2, 0, 0, 0);
    step("cont3", CONT, 0, 3, 0, 0, 0);
    step("jmp255", JUMP, 255, 255, 0, 0, 0);
    step("wrap", CONT, 0, 0, 0, 0, 0);

    // Memory wait: hold until selected condition rises.
    step("jmp20", JUMP, 20, 20, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("cwait_hold", CWAIT, 0, 20, 0, 0, 0);
    cond_in = 3'b001;
    step("cwait_go", CWAIT, 0, 21, 0, 0, 0);
    cond_in = 3'b000; cond_inv = 1'b1;
    step("jmp20b", JUMP, 20, 20, 0, 0, 0);
    step("cwait_inv", CWAIT, 0, 21, 0, 0, 0);
    cond_inv = 1'b0;

    // Dispatch and conditional branch, including out-of-range selector.
    step("jmp5", JUMP, 5, 5, 0, 0, 0);
    dispatch_addr = 38;
    step("dispatch", DISP, 0, 38, 0, 0, 0);
    step("jmp7a", JUMP, 7, 7, 0, 0, 0);
    step("cbr_nt", CBR, 60, 8, 0, 0, 0);
    cond_in = 3'b001;
    step("jmp7b", JUMP, 7, 7, 0, 0, 0);
    step("cbr_t", CBR, 60, 60, 0, 0, 0);
    cond_in = 3'b111; cond_sel = 2'd3;
    step("jmp7c", JUMP, 7, 7, 0, 0, 0);
    step("cbr_sel3", CBR, 60, 8, 0, 0, 0);
    cond_inv = 1'b1;
    step("jmp7d", JUMP, 7, 7, 0, 0, 0);
    step("cbr_sel3inv", CBR, 60, 60, 0, 0, 0);
    cond_in = '0; cond_sel = '0; cond_inv = 1'b0;

    // Nested calls and returns.
    step("jmp10", JUMP, 10, 10, 0, 0, 0);
    step("call40", CALL, 40, 40, 1, 0, 0);
    step("jmp41", JUMP, 41, 41, 1, 0, 0);
    step("call50", CALL, 50, 50, 2, 0, 0);
    step("jmp51", JUMP, 51, 51, 2, 0, 0);
    step("call70", CALL, 70, 70, 3, 0, 0);
    step("ret1", RET, 0, 52, 2, 0, 0);
    step("ret2", RET, 0, 42, 1, 0, 0);
    step("ret3", RET, 0, 11, 0, 0, 0);

    // Stall freezes CALL and a satisfied CWAIT.
    step("jmp10s", JUMP, 10, 10, 0, 0, 0);
    stall = 1'b1;
    step("stall_call", CALL, 40, 10, 0, 0, 0);
    stall = 1'b0;
    step("jmp20s", JUMP, 20, 20, 0, 0, 0);
    stall = 1'b1; cond_in = 3'b001;
    step("stall_cwait", CWAIT, 0, 20, 0, 0, 0);
    stall = 1'b0; cond_in = '0;

    // Overflow, underflow, restart; flags are sticky.
    step("jmp0", JUMP, 0, 0, 0, 0, 0);
    step("callA", CALL, 100, 100, 1, 0, 0);
    step("callB", CALL, 110, 110, 2, 0, 0);
    step("callC", CALL, 120, 120, 3, 0, 0);
    step("callD", CALL, 130, 130, 4, 0, 0);
    step("callE_ovf", CALL, 140, 140, 4, 1, 0);
    step("ret_full", RET, 0, 121, 3, 1, 0);
    step("restart", RESTART, 0, 1, 0, 1, 0);
    step("ret_unf", RET, 0, 1, 0, 1, 1);
    step("sticky", CONT, 0, 2, 0, 1, 1);

    // Asynchronous reset in the middle of a CALL.
    step("jmp10r", JUMP, 10, 10, 0, 1, 1);
    step("call40r", CALL, 40, 40, 1, 1, 1);
    ns_op = CALL; target = 50;
    #3;
    reset = 1'b1;
    #1;
    check("areset.upc", 32'(upc), 32'd0);
    check("areset.lvl", 32'(stack_level), 32'd0);
    check("areset.ovf", 32'(stack_ovf), 32'd0);
    check("areset.unf", 32'(stack_unf), 32'd0);
    $display("async reset   -> upc=%0d lvl=%0d ovf=%0b unf=%0b", upc, stack_level, stack_ovf, stack_unf);
    #2;
    reset = 1'b0;
    step("post_reset", CONT, 0, 1, 0, 0, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised next-address sequencer for the microprogrammed control unit. It replaces the fixed 8-bit incrementer, 4-way next-state mux and MOC/Cond inverter chain.
- Adds a selectable condition-input bank, conditional hold for memory wait, and a micro-subroutine call/return stack.
- Drives the microstore address; the microstore and control register stay external and feed `ns_op`, `cond_sel`, `cond_inv` and `target` back from the current microinstruction.

Parameters:
- ADDR_W, 8, microaddress width.
- COND_N, 4, number of condition inputs (e.g. MOC, Cond, …).
- SEL_W, 2, width of cond_sel; must satisfy 2^SEL_W >= COND_N.
- STACK_DEPTH, 4, return-stack entries (>=1).
- RESET_ADDR, 0, microaddress loaded on reset.
- FETCH_ADDR, 1, microaddress for RESTART and for recovery from stack underflow.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  freeze: upc, stack and flags hold their values.
- ns_op  in  3  next-state operation from the current microinstruction.
- target  in  ADDR_W  branch/call target from the microinstruction.
- dispatch_addr  in  ADDR_W  decoder (encoder) address for the current IR.
- cond_in  in  COND_N  condition bank.
- cond_sel  in  SEL_W  condition select.
- cond_inv  in  1  invert the selected condition.
- upc  out  ADDR_W  current microaddress (registered), drives the microstore.
- stack_level  out  clog2(STACK_DEPTH+1)  number of occupied stack entries.
- stack_ovf  out  1  sticky: a CALL was attempted while the stack was full.
- stack_unf  out  1  sticky: a RET was attempted while the stack was empty.

Behaviour:
- Reset (async, active-high) forces: upc=RESET_ADDR, stack_level=0, all stack entries 0, stack_ovf=0, stack_unf=0. Reset dominates stall and ns_op. Reset mid-CALL or mid-wait discards the operation.
- test = cond_in[cond_sel] XOR cond_inv. If cond_sel >= COND_N the selected condition is 0, so test = cond_inv.
- inc = (upc+1) mod 2^ADDR_W; the address wraps from all-ones to 0 with no flag.
- Next upc per ns_op, evaluated combinationally from the current cycle's inputs and registered on CLK:
  - 000 CONT: inc.
  - 001 JUMP: target.
  - 010 DISPATCH: dispatch_addr.
  - 011 CBR: test ? target : inc.
  - 100 CWAIT: test ? inc : upc. This is the memory-wait state; it holds until MOC with cond_sel=MOC.
  - 101 CALL: push inc, then upc=target.
  - 110 RET: pop, then upc=popped value.
  - 111 RESTART: FETCH_ADDR; the stack is flushed (stack_level=0); flags are unchanged.
- Stack is LIFO; push writes entry[stack_level] and increments the level; pop reads entry[stack_level-1] and decrements it.
- CALL while stack_level==STACK_DEPTH: the jump to target is still taken, the push is dropped, stack_ovf<=1.
- RET while stack_level==0: upc<=FETCH_ADDR, stack_unf<=1, the level stays 0.
- stack_ovf and stack_unf clear only on reset.
- stall=1: no state changes regardless of ns_op; stall takes priority over CWAIT completion and over CALL/RET.
- Latency: one cycle from microinstruction fields to the new upc. There is no combinational path from inputs to upc.
- All outputs are registered or derived from registers; none depend combinationally on inputs.

Test Plan:
- Reset, then CONT ×3 from RESET_ADDR=0 -> upc 0,1,2,3. Start upc=255 with CONT -> upc=0 (wrap), no flag raised.
- CWAIT with cond_sel=0, cond_inv=0, cond_in[0]=0 for 4 cycles, then 1 -> upc stays 20 for 4 cycles, then 21. Same sequence with cond_inv=1 -> advances immediately to 21.
- At upc=5: DISPATCH with dispatch_addr=38 -> upc=38. At upc=7: CBR target=60, test=0 -> 8; CBR with test=1 -> 60. cond_sel=3 with COND_N=3 and cond_inv=0 -> 8.
- Nested CALL depth 3 from upc 10→40, 41→50, 51→70, then RET ×3 -> upc 52, 42, 11; stack_level sequence 1,2,3,2,1,0.
- Five CALLs with STACK_DEPTH=4 -> fifth jumps to its target, stack_level stays 4, stack_ovf=1. RET on empty stack -> upc=FETCH_ADDR=1, stack_unf=1. Both flags stay 1 until reset.
- stall=1 during CALL and during satisfied CWAIT -> upc/level unchanged. Assert reset asynchronously mid-cycle during a CALL -> upc=0, level 0, flags 0 immediately, without waiting for a CLK edge.
